// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the pipelined Otter core. It owns the program
// counter, drives a synchronous-read instruction memory (one cycle latency),
// and fills the IF/DE pipeline register consumed by decode.
//
// Each cycle is in exactly one mode, in priority order:
//   reset > REDIRECT > STALL > RUN
//
//   REDIRECT : squash everything in flight, load the new target into the PC
//              and put a bubble into IF/DE.
//   STALL    : hold the PC and IF/DE. A word returning from memory is parked
//              in a one-entry skid buffer so that it is not lost.
//   RUN      : advance. IF/DE takes the skid word first, then the word
//              returning from memory, and otherwise a bubble. A new read is
//              issued at the current PC.
//
// Ports
//   IF_CLK       in   1  stage clock, rising edge
//   IF_RST       in   1  synchronous active-high reset
//   STALL        in   1  hold request from decode/hazard unit
//   REDIRECT     in   1  taken branch/jump resolved in execute
//   REDIRECT_PC  in  32  redirect target (bits [1:0] ignored)
//   IMEM_ADDR    out 32  instruction memory address (current PC)
//   IMEM_RD_EN   out  1  read strobe, data valid on IMEM_DOUT next cycle
//   IMEM_DOUT    in  32  word for the address strobed the previous cycle
//   IR           out 32  instruction to decode
//   PC_DE        out 32  PC of IR
//   PC_PLUS4     out 32  PC_DE + 4
//   IR_VALID     out  1  IR/PC_DE hold a real instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        IF_CLK,
    input  logic        IF_RST,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_RD_EN,
    input  logic [31:0] IMEM_DOUT,
    output logic [31:0] IR,
    output logic [31:0] PC_DE,
    output logic [31:0] PC_PLUS4,
    output logic        IR_VALID
);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_STALL = 2'd1,
        MODE_REDIR = 2'd2,
        MODE_RESET = 2'd3
    } mode_t;

    // Architectural state
    logic [31:0] r_pc_q;
    logic        r_inflight_v;
    logic [31:0] r_inflight_pc;
    logic        r_skid_v;
    logic [31:0] r_skid_ir;
    logic [31:0] r_skid_pc;
    logic [31:0] r_ir;
    logic [31:0] r_pc_de;
    logic [31:0] r_pc_plus4;
    logic        r_ir_valid;

    // Next-state values
    mode_t       w_mode;
    logic [31:0] w_pc_q;
    logic        w_inflight_v;
    logic [31:0] w_inflight_pc;
    logic        w_skid_v;
    logic [31:0] w_skid_ir;
    logic [31:0] w_skid_pc;
    logic [31:0] w_ir;
    logic [31:0] w_pc_de;
    logic [31:0] w_pc_plus4;
    logic        w_ir_valid;
    logic        w_rd_en;
    logic [31:0] w_redirect_pc;

    // PC arithmetic wraps modulo 2^32 with no indication.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        pc_inc = pc + 32'd4;
    endfunction

    assign w_redirect_pc = {REDIRECT_PC[31:2], 2'b00};

    // Mode decode: reset overrides redirect, redirect overrides stall.
    always_comb begin
        w_mode = MODE_RUN;
        if (IF_RST) begin
            w_mode = MODE_RESET;
        end else if (REDIRECT) begin
            w_mode = MODE_REDIR;
        end else if (STALL) begin
            w_mode = MODE_STALL;
        end else begin
            w_mode = MODE_RUN;
        end
    end

    // Next-state computation for PC, in-flight tracker, skid and IF/DE.
    always_comb begin
        w_pc_q        = r_pc_q;
        w_inflight_v  = r_inflight_v;
        w_inflight_pc = r_inflight_pc;
        w_skid_v      = r_skid_v;
        w_skid_ir     = r_skid_ir;
        w_skid_pc     = r_skid_pc;
        w_ir          = r_ir;
        w_pc_de       = r_pc_de;
        w_pc_plus4    = r_pc_plus4;
        w_ir_valid    = r_ir_valid;

        case (w_mode)
            MODE_RESET: begin
                w_pc_q        = RESET_VEC;
                w_inflight_v  = 1'b0;
                w_inflight_pc = RESET_VEC;
                w_skid_v      = 1'b0;
                w_skid_ir     = NOP_INSTR;
                w_skid_pc     = RESET_VEC;
                w_ir          = NOP_INSTR;
                w_ir_valid    = 1'b0;
                w_pc_de       = RESET_VEC;
                w_pc_plus4    = pc_inc(RESET_VEC);
            end

            MODE_REDIR: begin
                // The word returning this cycle belongs to the wrong path.
                w_pc_q       = w_redirect_pc;
                w_inflight_v = 1'b0;
                w_skid_v     = 1'b0;
                w_ir         = NOP_INSTR;
                w_ir_valid   = 1'b0;
            end

            MODE_STALL: begin
                // Park the returning word; an already-full skid simply holds.
                if (r_inflight_v) begin
                    w_skid_v     = 1'b1;
                    w_skid_ir    = IMEM_DOUT;
                    w_skid_pc    = r_inflight_pc;
                    w_inflight_v = 1'b0;
                end else begin
                    w_skid_v     = r_skid_v;
                end
            end

            MODE_RUN: begin
                // The skid word is older than anything in flight, so it goes first.
                if (r_skid_v) begin
                    w_ir       = r_skid_ir;
                    w_pc_de    = r_skid_pc;
                    w_pc_plus4 = pc_inc(r_skid_pc);
                    w_ir_valid = 1'b1;
                    w_skid_v   = 1'b0;
                end else if (r_inflight_v) begin
                    w_ir       = IMEM_DOUT;
                    w_pc_de    = r_inflight_pc;
                    w_pc_plus4 = pc_inc(r_inflight_pc);
                    w_ir_valid = 1'b1;
                end else begin
                    // Bubble: PC_DE/PC_PLUS4 keep their previous values.
                    w_ir       = NOP_INSTR;
                    w_ir_valid = 1'b0;
                end
                w_inflight_v  = 1'b1;
                w_inflight_pc = r_pc_q;
                w_pc_q        = pc_inc(r_pc_q);
            end

            default: begin
                w_pc_q     = RESET_VEC;
                w_ir       = NOP_INSTR;
                w_ir_valid = 1'b0;
            end
        endcase
    end

    // Read strobe: only RUN cycles issue a memory read.
    always_comb begin
        w_rd_en = 1'b0;
        case (w_mode)
            MODE_RUN:   w_rd_en = 1'b1;
            MODE_STALL: w_rd_en = 1'b0;
            MODE_REDIR: w_rd_en = 1'b0;
            MODE_RESET: w_rd_en = 1'b0;
            default:    w_rd_en = 1'b0;
        endcase
    end

    // State register for the whole stage (reset handled in the next-state logic).
    always_ff @(posedge IF_CLK) begin
        r_pc_q        <= w_pc_q;
        r_inflight_v  <= w_inflight_v;
        r_inflight_pc <= w_inflight_pc;
        r_skid_v      <= w_skid_v;
        r_skid_ir     <= w_skid_ir;
        r_skid_pc     <= w_skid_pc;
        r_ir          <= w_ir;
        r_pc_de       <= w_pc_de;
        r_pc_plus4    <= w_pc_plus4;
        r_ir_valid    <= w_ir_valid;
    end

    assign IMEM_ADDR  = r_pc_q;
    assign IMEM_RD_EN = w_rd_en;
    assign IR         = r_ir;
    assign PC_DE      = r_pc_de;
    assign PC_PLUS4   = r_pc_plus4;
    assign IR_VALID   = r_ir_valid;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_dout;
    logic [31:0] ir;
    logic [31:0] pc_de;
    logic [31:0] pc_plus4;
    logic        ir_valid;

    int checks;
    int errors;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .IF_CLK     (clk),
        .IF_RST     (rst),
        .STALL      (stall),
        .REDIRECT   (redirect),
        .REDIRECT_PC(redirect_pc),
        .IMEM_ADDR  (imem_addr),
        .IMEM_RD_EN (imem_rd_en),
        .IMEM_DOUT  (imem_dout),
        .IR         (ir),
        .PC_DE      (pc_de),
        .PC_PLUS4   (pc_plus4),
        .IR_VALID   (ir_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word at byte address A is 32'h1000_0000 + A/4.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        word_at = 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    // Synchronous-read instruction memory model.
    always @(posedge clk) begin
        if (imem_rd_en) imem_dout <= word_at(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full IF/DE register contents.
    task automatic chk_ifde(input string tag, input logic v, input logic [31:0] e_ir,
                            input logic [31:0] e_pc);
        chk({tag, ".valid"}, {31'd0, ir_valid}, {31'd0, v});
        chk({tag, ".ir"}, ir, e_ir);
        chk({tag, ".pc_de"}, pc_de, e_pc);
        chk({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_dout   = 32'h0;

        // Reset
        #2;
        chk("rst.rd_en", {31'd0, imem_rd_en}, 32'd0);
        step();
        step();
        chk_ifde("rst", 1'b0, NOP, 32'h0);
        rst = 1'b0;
        #1;
        chk("cold.rd_en", {31'd0, imem_rd_en}, 32'd1);
        chk("cold.addr", imem_addr, 32'h0);

        // Cold start: first valid after the second edge
        step();
        chk_ifde("cold.e1", 1'b0, NOP, 32'h0);
        step();
        chk_ifde("cold.e2", 1'b1, 32'h1000_0000, 32'h0);
        step();
        chk_ifde("run.e3", 1'b1, 32'h1000_0001, 32'h4);
        step();
        chk_ifde("run.e4", 1'b1, 32'h1000_0002, 32'h8);

        // Stall for three cycles with PC_DE = 8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.rd_en", {31'd0, imem_rd_en}, 32'd0);
            step();
            chk_ifde("stall.hold", 1'b1, 32'h1000_0002, 32'h8);
        end
        stall = 1'b0;
        step();
        chk_ifde("rel.skid", 1'b1, 32'h1000_0003, 32'hC);
        step();
        chk_ifde("rel.next", 1'b1, 32'h1000_0004, 32'h10);

        // Redirect to 0x103 (low bits dropped -> 0x100)
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        chk("redir.rd_en", {31'd0, imem_rd_en}, 32'd0);
        step();
        redirect = 1'b0;
        chk_ifde("redir.b1", 1'b0, NOP, 32'h10);
        chk("redir.addr", imem_addr, 32'h100);
        step();
        chk_ifde("redir.b2", 1'b0, NOP, 32'h10);
        step();
        chk_ifde("redir.tgt", 1'b1, 32'h1000_0040, 32'h100);

        // Fill skid with a stall, then stall+redirect to 0x200
        stall = 1'b1;
        step();
        chk_ifde("sr.stall", 1'b1, 32'h1000_0040, 32'h100);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        chk_ifde("sr.b1", 1'b0, NOP, 32'h100);
        step();
        chk_ifde("sr.b2", 1'b0, NOP, 32'h100);
        step();
        chk_ifde("sr.tgt", 1'b1, 32'h1000_0080, 32'h200);

        // Wrap-around from 0xFFFF_FFFC
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        step();
        step();
        chk_ifde("wrap.top", 1'b1, 32'h4FFF_FFFF, 32'hFFFF_FFFC);
        chk("wrap.p4a", pc_plus4, 32'h0000_0000);
        step();
        chk_ifde("wrap.zero", 1'b1, 32'h1000_0000, 32'h0);
        chk("wrap.p4b", pc_plus4, 32'h0000_0004);

        // Reset while stalled with a full skid
        stall = 1'b1;
        step();
        chk_ifde("rs.stall", 1'b1, 32'h1000_0000, 32'h0);
        rst = 1'b1;
        #1;
        chk("rs.rd_en", {31'd0, imem_rd_en}, 32'd0);
        step();
        rst   = 1'b0;
        stall = 1'b0;
        chk_ifde("rs.rst", 1'b0, NOP, 32'h0);
        #1;
        chk("rs.addr", imem_addr, 32'h0);
        step();
        chk_ifde("rs.e1", 1'b0, NOP, 32'h0);
        step();
        chk_ifde("rs.e2", 1'b1, 32'h1000_0000, 32'h0);
        step();
        chk_ifde("rs.e3", 1'b1, 32'h1000_0001, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined Otter: owns the program counter, drives the synchronous-read instruction memory, and fills the IF/DE pipeline register that supplies `IR` and the matching PC to the decode stage. It honours decode stalls without losing the in-flight memory word and squashes wrong-path fetches on a branch/jump redirect from execute.

## Interface
- `RESET_VEC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0013, value driven on `IR` whenever `IR_VALID`=0 (addi x0,x0,0)

Ports:
- `IF_CLK`  in  1  stage clock; all state updates on rising edge
- `IF_RST`  in  1  reset, synchronous, active-high
- `STALL`  in  1  decode/hazard unit requests IF/DE hold
- `REDIRECT`  in  1  execute resolved a taken branch/jump; flush fetch
- `REDIRECT_PC`  in  32  target PC; bits [1:0] ignored and treated as 00
- `IMEM_ADDR`  out  32  instruction memory address; equals internal `pc_q`
- `IMEM_RD_EN`  out  1  read strobe; data returns on `IMEM_DOUT` one cycle later
- `IMEM_DOUT`  in  32  instruction word for the address strobed the previous cycle
- `IR`  out  32  registered instruction to decode
- `PC_DE`  out  32  registered PC of `IR`
- `PC_PLUS4`  out  32  registered `PC_DE`+4, mod 2^32
- `IR_VALID`  out  1  `IR`/`PC_DE` hold a real instruction

## Operation
- Internal state: `pc_q` (next fetch address), `inflight_v`/`inflight_pc` (read issued last cycle), `skid_v`/`skid_ir`/`skid_pc` (word captured during stall), IF/DE register.
- Each cycle falls in exactly one mode, priority REDIRECT > STALL > RUN.
- REDIRECT: `IMEM_RD_EN`=0; `pc_q`<=`{REDIRECT_PC[31:2],2'b00}`; `inflight_v`<=0; `skid_v`<=0; `IR_VALID`<=0, `IR`<=`NOP_INSTR`. Returning memory word discarded.
- STALL: `IMEM_RD_EN`=0; `pc_q` and IF/DE register hold. If `inflight_v`, capture `IMEM_DOUT`/`inflight_pc` into skid, set `skid_v`, clear `inflight_v`. Existing skid contents held.
- RUN: IF/DE loads, in priority: skid (then `skid_v`<=0) if `skid_v`; else `IMEM_DOUT`/`inflight_pc` if `inflight_v`; else bubble (`IR_VALID`<=0, `IR`<=`NOP_INSTR`). Simultaneously `IMEM_RD_EN`=1, `inflight_pc`<=`pc_q`, `inflight_v`<=1, `pc_q`<=`pc_q`+4.
- `skid_v` and `inflight_v` never both 1.
- `PC_PLUS4` always equals `PC_DE`+4 when updated; bubbles load `PC_DE`<=`pc` of nothing: hold previous `PC_DE`.
- PC arithmetic 32-bit unsigned, wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.

## Timing
- Reset (`IF_RST`=1 at edge): `pc_q`=`RESET_VEC`, `inflight_v`=0, `skid_v`=0, `IR`=`NOP_INSTR`, `IR_VALID`=0, `PC_DE`=`RESET_VEC`, `PC_PLUS4`=`RESET_VEC`+4. `IMEM_RD_EN`=0 while `IF_RST`=1.
- Reset mid-operation overrides REDIRECT/STALL; in-flight and skid words dropped.
- Cold start: first cycle after reset issues `RESET_VEC`; `IR_VALID`=1 with `PC_DE`=`RESET_VEC` after the second edge.
- Steady state: one instruction per cycle, 1-cycle memory latency hidden by `inflight`.
- Redirect at cycle N: target issued N+1, valid in IF/DE after edge N+2; two bubbles (after edges N and N+1).
- Stall release: skid word enters IF/DE on first RUN edge, next sequential word the edge after; no bubble, no duplicate, no loss.
- STALL and REDIRECT together: redirect semantics; stall ignored.
- `IMEM_ADDR` combinational from `pc_q`; meaningful only when `IMEM_RD_EN`=1.

## Test plan
- Reset, RESET_VEC=0, memory word[i]=32'h1000_0000+i -> IR_VALID first 1 after 2nd edge with IR=32'h1000_0000, PC_DE=0; then PC_DE 4, 8, 12 each cycle.
- STALL high 3 cycles while PC_DE=8 -> IR/PC_DE hold 8; after release PC_DE=12 then 16, no gaps, IMEM_RD_EN=0 during stall.
- REDIRECT with REDIRECT_PC=32'h0000_0103 at PC_DE=16 -> two IR_VALID=0 cycles with IR=32'h0000_0013, then PC_DE=32'h100, PC_PLUS4=32'h104.
- STALL and REDIRECT same cycle (target 32'h200) -> skid dropped, PC_DE=32'h200 two cycles later, no stale word emitted.
- pc_q at 32'hFFFF_FFFC, run -> PC_DE FFFF_FFFC then 0000_0000, PC_PLUS4 0000_0000 then 0000_0004.
- IF_RST asserted during stall with skid full -> next outputs IR_VALID=0, IR=NOP_INSTR; fetch restarts at RESET_VEC.
